// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package riscv_bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Saturating up/down step for a counter of cnt_bits width (2..4), carried in 4 bits.
  function automatic logic [3:0] sat_update(input logic [3:0] cnt, input logic taken,
                                            input int unsigned cnt_bits);
    logic [3:0] top;
    top = 4'((1 << cnt_bits) - 1);
    if (taken) return (cnt >= top) ? top : cnt + 4'd1;
    else       return (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on collision).
module rl_ram_1r1w #(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] wdata_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [DBITS-1:0] rdata_o
);

  logic [DBITS-1:0] mem_reg [2**ABITS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_reg[waddr_i] <= wdata_i;
    rdata_o <= mem_reg[raddr_i];
  end

endmodule

// File: rtl/riscv_bp_gshare.sv
// Gshare direction predictor: PC xor global history indexes a table of saturating counters.
// Optional same-cycle write-to-read forwarding is enabled by defining RISCV_BP_BYPASS_EN.
module riscv_bp_gshare
  import riscv_bp_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_INIT  = 'h200,
  parameter int unsigned     IDX_BITS = 10,
  parameter int unsigned     IDX_LSB  = 2,
  parameter int unsigned     GHR_BITS = 8,
  parameter int unsigned     CNT_BITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_stall_i,
  input  logic [XLEN-1:0]     if_parcel_pc_i,
  input  logic                if_branch_i,
  output logic                bp_ready_o,
  output logic                bp_taken_o,
  output logic [CNT_BITS-1:0] bp_counter_o,
  output logic [GHR_BITS-1:0] bp_history_o,
  input  logic [XLEN-1:0]     ex_pc_i,
  input  logic [GHR_BITS-1:0] bu_bp_history_i,
  input  logic [CNT_BITS-1:0] bu_bp_counter_i,
  input  logic                bu_bp_btaken_i,
  input  logic                bu_bp_update_i,
  input  logic                bu_bp_mispredict_i
);

  localparam int unsigned DEPTH = 2**IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

  bp_state_e           state_reg;
  logic [IDX_BITS-1:0] init_idx_reg;
  logic [XLEN-1:0]     pc_hold_reg;
  logic [GHR_BITS-1:0] ghr_reg, ghr_next, ghr_hold_reg, hist_out_reg;
  logic                rd_ok_reg;

  logic [XLEN-1:0]     pc_sel;
  logic [GHR_BITS-1:0] ghr_sel, ghr_shift, ghr_repair;
  logic [IDX_BITS-1:0] rd_idx, wr_idx, ram_waddr;
  logic [CNT_BITS-1:0] cnt_new, ram_wdata, ram_rdata, cnt_rd;
  logic                upd_en, ram_we;
  logic                pc_unused;

  // Only the index slice of the PCs matters to the table.
  assign pc_unused = ^{ex_pc_i, pc_hold_reg};

  assign pc_sel  = id_stall_i ? pc_hold_reg  : if_parcel_pc_i;
  assign ghr_sel = id_stall_i ? ghr_hold_reg : ghr_reg;
  assign rd_idx  = pc_sel[IDX_LSB +: IDX_BITS] ^ IDX_BITS'(ghr_sel);
  assign wr_idx  = ex_pc_i[IDX_LSB +: IDX_BITS] ^ IDX_BITS'(bu_bp_history_i);

  assign upd_en  = (state_reg == ST_RUN) && bu_bp_update_i;
  assign cnt_new = CNT_BITS'(sat_update(4'(bu_bp_counter_i), bu_bp_btaken_i, CNT_BITS));

  if (GHR_BITS == 1) begin : g_ghr_one
    assign ghr_shift  = bp_taken_o;
    assign ghr_repair = bu_bp_btaken_i;
  end else begin : g_ghr_multi
    assign ghr_shift  = {ghr_reg[GHR_BITS-2:0], bp_taken_o};
    assign ghr_repair = {bu_bp_history_i[GHR_BITS-2:0], bu_bp_btaken_i};
  end

  // Repair from execute overrides the speculative shift from fetch.
  always_comb begin
    ghr_next = ghr_reg;
    if (state_reg == ST_RUN) begin
      if (bu_bp_mispredict_i)              ghr_next = ghr_repair;
      else if (if_branch_i && !id_stall_i) ghr_next = ghr_shift;
    end
  end

  always_comb begin
    ram_we    = upd_en;
    ram_waddr = wr_idx;
    ram_wdata = cnt_new;
    if (state_reg == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_idx_reg;
      ram_wdata = CNT_WNT;
    end
  end

  rl_ram_1r1w #(
    .ABITS(IDX_BITS),
    .DBITS(CNT_BITS)
  ) u_table (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(rd_idx),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_INIT;
      init_idx_reg <= '0;
      ghr_reg      <= '0;
      ghr_hold_reg <= '0;
      pc_hold_reg  <= PC_INIT;
      hist_out_reg <= '0;
      rd_ok_reg    <= 1'b0;
    end else begin
      ghr_reg      <= ghr_next;
      rd_ok_reg    <= (state_reg == ST_RUN);
      hist_out_reg <= (state_reg == ST_RUN) ? ghr_sel : '0;
      if (!id_stall_i) begin
        pc_hold_reg  <= if_parcel_pc_i;
        ghr_hold_reg <= ghr_reg;
      end
      case (state_reg)
        ST_INIT: begin
          init_idx_reg <= init_idx_reg + 1'b1;
          if (init_idx_reg == IDX_BITS'(DEPTH - 1)) state_reg <= ST_RUN;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef RISCV_BP_BYPASS_EN
  logic                byp_hit_reg;
  logic [CNT_BITS-1:0] byp_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_hit_reg <= 1'b0;
      byp_cnt_reg <= '0;
    end else begin
      byp_hit_reg <= upd_en && (wr_idx == rd_idx);
      byp_cnt_reg <= cnt_new;
    end
  end

  assign cnt_rd = byp_hit_reg ? byp_cnt_reg : ram_rdata;
`else
  assign cnt_rd = ram_rdata;
`endif

  assign bp_ready_o   = (state_reg == ST_RUN);
  assign bp_counter_o = rd_ok_reg ? cnt_rd : '0;
  assign bp_taken_o   = bp_counter_o[CNT_BITS-1];
  assign bp_history_o = hist_out_reg;

endmodule

// File: tb/tb_riscv_bp_gshare.sv
// Self-checking bench for riscv_bp_gshare at IDX_BITS=6, GHR_BITS=4, CNT_BITS=2.
module tb_riscv_bp_gshare;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        br;
    logic        upd;
    logic [31:0] ex_pc;
    logic [3:0]  hist;
    logic [1:0]  cnt;
    logic        bt;
    logic        mp;
    logic [1:0]  exp_cnt;
    logic [3:0]  exp_hist;
  } vec_t;

  typedef struct {
    logic [1:0] cnt;
    logic [3:0] hist;
  } exp_t;

`ifdef RISCV_BP_BYPASS_EN
  localparam logic [1:0] COLL_EXP = 2'd2;
`else
  localparam logic [1:0] COLL_EXP = 2'd1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br, upd, bt, mp;
  logic [31:0] pc, ex_pc;
  logic [3:0]  hist;
  logic [1:0]  cnt;
  logic        bp_ready, bp_taken;
  logic [1:0]  bp_counter;
  logic [3:0]  bp_history;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[20];

  always #5 clk = ~clk;

  riscv_bp_gshare #(
    .XLEN(32), .PC_INIT(32'h200), .IDX_BITS(6), .IDX_LSB(2), .GHR_BITS(4), .CNT_BITS(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_stall_i(stall), .if_parcel_pc_i(pc), .if_branch_i(br),
    .bp_ready_o(bp_ready), .bp_taken_o(bp_taken), .bp_counter_o(bp_counter),
    .bp_history_o(bp_history), .ex_pc_i(ex_pc), .bu_bp_history_i(hist),
    .bu_bp_counter_i(cnt), .bu_bp_btaken_i(bt), .bu_bp_update_i(upd),
    .bu_bp_mispredict_i(mp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic s, input logic b,
                              input logic u, input logic [31:0] xp, input logic [3:0] h,
                              input logic [1:0] c, input logic t, input logic m,
                              input logic [1:0] ec, input logic [3:0] eh);
    vec_t v;
    v.pc = p; v.stall = s; v.br = b; v.upd = u; v.ex_pc = xp; v.hist = h;
    v.cnt = c; v.bt = t; v.mp = m; v.exp_cnt = ec; v.exp_hist = eh;
    return v;
  endfunction

  function automatic vec_t rd(input logic [31:0] p, input logic b,
                              input logic [1:0] ec, input logic [3:0] eh);
    return mk(p, 1'b0, b, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0, ec, eh);
  endfunction

  task automatic clear_inputs();
    stall = 0; br = 0; upd = 0; bt = 0; mp = 0;
    pc = 32'h0; ex_pc = 32'h0; hist = 4'h0; cnt = 2'd0;
  endtask

  // Drive one cycle, queue its expectation, then compare against the output after the edge.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    pc = v.pc; stall = v.stall; br = v.br; upd = v.upd; ex_pc = v.ex_pc;
    hist = v.hist; cnt = v.cnt; bt = v.bt; mp = v.mp;
    e.cnt = v.exp_cnt; e.hist = v.exp_hist;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    $display("txn %s pc=%0h cnt=%0d hist=%b taken=%0d", nm, v.pc, bp_counter, bp_history, bp_taken);
    chk({nm, "_cnt"}, 32'(bp_counter), 32'(e.cnt));
    chk({nm, "_hist"}, 32'(bp_history), 32'(e.hist));
    chk({nm, "_taken"}, 32'(bp_taken), 32'(e.cnt[1]));
  endtask

  task automatic wait_ready(input string nm, input bit poke_update);
    int n;
    n = 0;
    while (!bp_ready && n < 200) begin
      if (poke_update && n == 20) begin
        upd = 1; ex_pc = 32'h114; hist = 4'h0; cnt = 2'd1; bt = 1;
      end else begin
        upd = 0; bt = 0; cnt = 2'd0; ex_pc = 32'h0;
      end
      step();
      n++;
      if (!bp_ready) chk({nm, "_init_cnt"}, 32'(bp_counter), 32'h0);
    end
    clear_inputs();
    chk({nm, "_ready_latency"}, 32'(n), 32'd64);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Saturation sequence then history build-up (entries: 0->11, 2->00, rest 01).
    tbl[0]  = mk(32'h104, 0, 0, 1, 32'h100, 4'h0, 2'd1, 1, 0, 2'd1, 4'h0);
    tbl[1]  = rd(32'h100, 0, 2'd2, 4'h0);
    tbl[2]  = mk(32'h104, 0, 0, 1, 32'h100, 4'h0, 2'd2, 1, 0, 2'd1, 4'h0);
    tbl[3]  = rd(32'h100, 0, 2'd3, 4'h0);
    tbl[4]  = mk(32'h104, 0, 0, 1, 32'h100, 4'h0, 2'd3, 1, 0, 2'd1, 4'h0);
    tbl[5]  = rd(32'h100, 0, 2'd3, 4'h0);
    tbl[6]  = mk(32'h104, 0, 0, 1, 32'h108, 4'h0, 2'd1, 0, 0, 2'd1, 4'h0);
    tbl[7]  = rd(32'h108, 0, 2'd0, 4'h0);
    tbl[8]  = mk(32'h104, 0, 0, 1, 32'h108, 4'h0, 2'd0, 0, 0, 2'd1, 4'h0);
    tbl[9]  = rd(32'h108, 0, 2'd0, 4'h0);
    tbl[10] = rd(32'h100, 0, 2'd3, 4'h0);
    tbl[11] = rd(32'h10C, 1, 2'd1, 4'h0);
    tbl[12] = rd(32'h110, 0, 2'd1, 4'h1);
    tbl[13] = rd(32'h10C, 1, 2'd0, 4'h1);
    tbl[14] = rd(32'h108, 0, 2'd3, 4'h2);
    tbl[15] = rd(32'h10C, 1, 2'd1, 4'h2);
    tbl[16] = rd(32'h114, 0, 2'd3, 4'h5);
    tbl[17] = rd(32'h10C, 1, 2'd1, 4'h5);
    tbl[18] = rd(32'h100, 0, 2'd1, 4'hB);
    tbl[19] = rd(32'h12C, 0, 2'd3, 4'hB);

    step(); step();
    chk("rst_ready", 32'(bp_ready), 32'h0);
    chk("rst_counter", 32'(bp_counter), 32'h0);
    chk("rst_taken", 32'(bp_taken), 32'h0);
    chk("rst_history", 32'(bp_history), 32'h0);

    rst_n = 1'b1;
    wait_ready("boot", 1'b1);

    for (int i = 0; i < 64; i++)
      run_vec(rd(32'h100 + 32'(i) * 4, 0, 2'd1, 4'h0), $sformatf("sweep%0d", i));

    for (int i = 0; i < 20; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // Repair beats the shift in the same cycle: 0110 + taken -> 1101.
    run_vec(mk(32'h100, 0, 1, 0, 32'h0, 4'b0110, 2'd0, 1, 1, 2'd1, 4'hB), "repair");
    run_vec(rd(32'h100, 0, 2'd1, 4'hD), "post_repair");

    // Stall with moving PC and a stray branch flag: outputs must hold.
    for (int i = 0; i < 5; i++)
      run_vec(mk(32'h134 + 32'(i) * 4, 1, 1, 0, 32'h0, 4'h0, 2'd0, 0, 0, 2'd1, 4'hD),
              $sformatf("stall%0d", i));
    run_vec(rd(32'h100, 0, 2'd1, 4'hD), "unstall");

    // Same-cycle write and read of index 5 (0x120 ^ 1101 and 0x114 ^ 0000).
    run_vec(mk(32'h120, 0, 0, 1, 32'h114, 4'h0, 2'd1, 1, 0, COLL_EXP, 4'hD), "collide");
    run_vec(rd(32'h120, 0, 2'd2, 4'hD), "post_collide");

    // Asynchronous reset mid-RUN restarts a full sweep.
    rst_n = 1'b0;
    #1;
    chk("rerst_ready", 32'(bp_ready), 32'h0);
    chk("rerst_counter", 32'(bp_counter), 32'h0);
    chk("rerst_history", 32'(bp_history), 32'h0);
    step();
    rst_n = 1'b1;
    wait_ready("reboot", 1'b0);
    run_vec(rd(32'h100, 0, 2'd1, 4'h0), "reinit_entry0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
